// File: rtl/regsched_pkg.sv
// Shared constants, write-source tag and helpers for the register-file write scheduler.
package regsched_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_SKID = 2'd2,
    SRC_LU   = 2'd3
  } wsrc_t;

  function automatic logic [5:0] count_ones(input logic [NUM_REGS-1:0] vec);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + {5'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/write_skid_buffer.sv
// One-entry holding buffer for an LU result that arrived while WB owned the write port.
module write_skid_buffer
  import regsched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_reg,
  input  logic [DATA_W-1:0] lu_data,
  input  logic              port_taken,
  output logic              lu_ready,
  output logic              full,
  output logic [ADDR_W-1:0] entry_reg,
  output logic [DATA_W-1:0] entry_data
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic              capture_s;
  logic [ADDR_W-1:0] entry_reg_r;
  logic [DATA_W-1:0] entry_data_r;

  assign lu_ready   = (state_r == ST_EMPTY);
  assign full       = (state_r == ST_FULL);
  assign entry_reg  = entry_reg_r;
  assign entry_data = entry_data_r;

  // Next-state: capture only a non-zero LU result that lost the port to WB
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (lu_valid && (lu_reg != ZERO_REG) && port_taken) begin
          state_nxt_s = ST_FULL;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (!port_taken) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // State and entry storage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_EMPTY;
      entry_reg_r  <= 5'd0;
      entry_data_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        entry_reg_r  <= lu_reg;
        entry_data_r <= lu_data;
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register-file write port between WB and the mul/div unit and
// tracks registers awaiting LU results to stall decode on hazards.
module regfile_write_scheduler
  import regsched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_reg,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] chk_rs,
  input  logic [ADDR_W-1:0] chk_rt,
  output logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [5:0]        busy_count
);

  logic              wb_take_s;
  logic              skid_full_s;
  logic [ADDR_W-1:0] skid_reg_s;
  logic [DATA_W-1:0] skid_data_s;
  wsrc_t             sel_src_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;
  wsrc_t             src_r;
  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [5:0]        busy_count_r;
  logic              issue_fire_s;
  logic              lu_commit_s;

  assign wb_take_s = wb_valid && (wb_reg != ZERO_REG);

  write_skid_buffer u_skid (
    .clk        (clk),
    .reset      (reset),
    .lu_valid   (lu_valid),
    .lu_reg     (lu_reg),
    .lu_data    (lu_data),
    .port_taken (wb_take_s),
    .lu_ready   (lu_ready),
    .full       (skid_full_s),
    .entry_reg  (skid_reg_s),
    .entry_data (skid_data_s)
  );

  // Fixed-priority port selection: WB, then skid entry, then direct LU
  always_comb begin
    sel_src_s  = SRC_NONE;
    sel_addr_s = 5'd0;
    sel_data_s = 32'd0;
    if (wb_take_s) begin
      sel_src_s  = SRC_WB;
      sel_addr_s = wb_reg;
      sel_data_s = wb_data;
    end else if (skid_full_s) begin
      sel_src_s  = SRC_SKID;
      sel_addr_s = skid_reg_s;
      sel_data_s = skid_data_s;
    end else if (lu_valid && lu_ready && (lu_reg != ZERO_REG)) begin
      sel_src_s  = SRC_LU;
      sel_addr_s = lu_reg;
      sel_data_s = lu_data;
    end else begin
      sel_src_s  = SRC_NONE;
    end
  end

  // Registered write port plus the source tag that rides along with it
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= 32'd0;
      src_r      <= SRC_NONE;
    end else begin
      rf_we_r    <= (sel_src_s != SRC_NONE);
      rf_waddr_r <= sel_addr_s;
      rf_wdata_r <= sel_data_s;
      src_r      <= sel_src_s;
    end
  end

  assign stall        = busy_r[chk_rs] | busy_r[chk_rt] | (issue_valid & busy_r[issue_reg]);
  assign issue_fire_s = issue_valid && !stall && (issue_reg != ZERO_REG);
  assign lu_commit_s  = rf_we_r && ((src_r == SRC_SKID) || (src_r == SRC_LU));

  // Scoreboard next value: clear on LU commit, then set (set wins on a tie)
  always_comb begin
    busy_nxt_s = busy_r;
    if (lu_commit_s) begin
      busy_nxt_s[rf_waddr_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (issue_fire_s) begin
      busy_nxt_s[issue_reg] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard and its population count update together
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r       <= 32'd0;
      busy_count_r <= 6'd0;
    end else begin
      busy_r       <= busy_nxt_s;
      busy_count_r <= count_ones(busy_nxt_s);
    end
  end

  assign rf_we      = rf_we_r;
  assign rf_waddr   = rf_waddr_r;
  assign rf_wdata   = rf_wdata_r;
  assign busy_count = busy_count_r;

endmodule
